// File: rtl/clk_bufg_pkg.sv
// clk_bufg_pkg: default configuration constants for the clk_bufg clock buffer
package clk_bufg_pkg;
  localparam int   SYNC_STAGES_DEF = 2;
  localparam int   CNT_WIDTH_DEF   = 16;
  localparam logic INIT_EN_DEF     = 1'b1;
endpackage

// File: rtl/clk_bufg_sync.sv
// clk_bufg_sync: multi-flop synchronizer for the asynchronous clock-enable request
module clk_bufg_sync import clk_bufg_pkg::*; #(
  parameter int   STAGES = SYNC_STAGES_DEF,
  parameter logic INIT   = INIT_EN_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sync_q <= {STAGES{INIT}};
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/clk_bufg.sv
// clk_bufg: glitch-free gated global clock buffer with edge counter; gating enabled by CLK_BUFG_GATE_EN
module clk_bufg import clk_bufg_pkg::*; #(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter logic INIT_EN     = INIT_EN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  output logic                 O,
  output logic                 active,
  output logic [CNT_WIDTH-1:0] edge_cnt
);
  logic [1:0]           rst_q;
  logic                 rst_s;
  logic                 en;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) rst_q <= 2'b11;
    else       rst_q <= {rst_q[0], 1'b0};
  assign rst_s = rst_q[1];
`ifdef CLK_BUFG_GATE_EN
  logic ce_s, en_q;
  clk_bufg_sync #(.STAGES(SYNC_STAGES), .INIT(INIT_EN)) u_sync (
    .clk_i(clk),
    .rst_i(rst_s),
    .d_i  (ce),
    .q_o  (ce_s)
  );
  // enable only moves while clk is low, so AND-gating can never chop a high phase
  always_ff @(negedge clk or posedge rst_s)
    if (rst_s) en_q <= INIT_EN;
    else       en_q <= ce_s;
  assign en = en_q;
`else
  logic unused_cfg;
  assign unused_cfg = ce ^ INIT_EN ^ (SYNC_STAGES > 2);
  assign en = 1'b1;
`endif
  assign O        = clk & en;
  assign active   = en;
  assign cnt_d    = en ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  assign edge_cnt = cnt_q;
  always_ff @(posedge clk or posedge rst_s)
    if (rst_s) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: tb/tb_clk_bufg.sv
// tb_clk_bufg: directed self-checking bench for clk_bufg in gated or ungated build
module tb_clk_bufg;
`ifdef CLK_BUFG_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif
  logic clk = 1'b0, reset_a = 1'b0, reset_b = 1'b0, ce_a = 1'b1, ce_b = 1'b1;
  logic O_a, active_a, O_b, active_b;
  logic [15:0] cnt_a;
  logic [7:0]  cnt_b;
  int n_chk = 0, n_fail = 0;
  longint t_rise = 0;
  clk_bufg #(.SYNC_STAGES(2), .CNT_WIDTH(16), .INIT_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .ce(ce_a), .O(O_a), .active(active_a), .edge_cnt(cnt_a)
  );
  clk_bufg #(.SYNC_STAGES(2), .CNT_WIDTH(8), .INIT_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .ce(ce_b), .O(O_b), .active(active_b), .edge_cnt(cnt_b)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic negs();
    @(negedge clk); #1;
  endtask
  always @(posedge O_a) begin
    t_rise = $time;
    check("o_rise_align", 32'($time % 10), 5);
  end
  always @(negedge O_a) check("o_width", 32'($time - t_rise), 5);
  initial begin
    #1 reset_a = 1'b1; reset_b = 1'b1;
    tick();
    check("a_rst_o", 32'(O_a), 1);
    check("a_rst_act", 32'(active_a), 1);
    check("a_rst_cnt", 32'(cnt_a), 0);
    check("b_rst_o", 32'(O_b), GATED ? 0 : 1);
    check("b_rst_act", 32'(active_b), GATED ? 0 : 1);
    check("b_rst_cnt", 32'(cnt_b), 0);
    negs();
    check("a_rst_o_low", 32'(O_a), 0);
    tick();
    tick();
    reset_a = 1'b0; reset_b = 1'b0;
    tick();
    check("a_rel_cnt0", 32'(cnt_a), 0);
    tick();
    check("a_rel_cnt1", 32'(cnt_a), 0);
    tick();
    check("a_first_cnt", 32'(cnt_a), 1);
    check("a_first_act", 32'(active_a), 1);
    check("a_first_o", 32'(O_a), 1);
    check("b_first_cnt", 32'(cnt_b), GATED ? 0 : 1);
    check("b_first_o", 32'(O_b), GATED ? 0 : 1);
    #2 ce_a = 1'b0;
    tick();
    check("a_off_n_o", 32'(O_a), 1);
    check("a_off_n_cnt", 32'(cnt_a), 2);
    tick();
    check("a_off_n1_o", 32'(O_a), 1);
    check("a_off_n1_cnt", 32'(cnt_a), 3);
    negs();
    check("a_off_act", 32'(active_a), GATED ? 0 : 1);
    tick();
    check("a_off_n2_o", 32'(O_a), GATED ? 0 : 1);
    check("a_off_n2_cnt", 32'(cnt_a), GATED ? 3 : 4);
    repeat (20) tick();
    check("a_off_hold_o", 32'(O_a), GATED ? 0 : 1);
    check("a_off_hold_cnt", 32'(cnt_a), GATED ? 3 : 24);
    #2 ce_a = 1'b1;
    tick();
    check("a_on_m_o", 32'(O_a), GATED ? 0 : 1);
    tick();
    check("a_on_m1_act", 32'(active_a), GATED ? 0 : 1);
    tick();
    check("a_on_m2_o", 32'(O_a), 1);
    check("a_on_m2_act", 32'(active_a), 1);
    check("a_on_m2_cnt", 32'(cnt_a), GATED ? 4 : 27);
    check("b_pre_o", 32'(O_b), 1);
    #1 reset_b = 1'b1;
    #1;
    check("b_async_o", 32'(O_b), GATED ? 0 : 1);
    check("b_async_act", 32'(active_b), GATED ? 0 : 1);
    check("b_async_cnt", 32'(cnt_b), 0);
    tick();
    tick();
    reset_b = 1'b0;
    repeat (GATED ? 5 : 3) tick();
    check("b_wrap_start", 32'(cnt_b), 1);
    repeat (254) tick();
    check("b_wrap_255", 32'(cnt_b), 255);
    tick();
    check("b_wrap_0", 32'(cnt_b), 0);
    repeat (4) tick();
    check("b_wrap_4", 32'(cnt_b), 4);
    @(posedge clk); #2 reset_a = 1'b1;
    #1;
    check("a_async_o", 32'(O_a), 1);
    check("a_async_act", 32'(active_a), 1);
    check("a_async_cnt", 32'(cnt_a), 0);
    negs();
    check("a_async_o_low", 32'(O_a), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
